// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/redirect controller for the 5-stage 8-bit pipeline: ALU forwarding, load-use stalls, MEM-resolved redirects.
// Optional performance counters (stall_cnt/flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int REG_AW       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_wr_addr,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_wr_addr,
  input  logic              mem_regwrite,
  input  logic              mem_branch,
  input  logic              mem_branchflip,
  input  logic              mem_zr,
  input  logic              mem_jump,
  input  logic [REG_AW-1:0] wb_wr_addr,
  input  logic              wb_regwrite,
  output logic              pc_write,
  output logic [1:0]        pc_sel,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
`ifdef HAZARD_PERF_CNT_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic              stalled
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [3:0] STALL_INIT  = 4'(STALL_CYCLES - 1);
  localparam bit         MULTI_STALL = (STALL_CYCLES > 1);

  state_t      state_reg;
  logic [3:0]  cnt_reg;

  logic              taken;
  logic              redirect;
  logic              lh;
  logic [REG_AW-1:0] ex_src [2];
  logic [1:0]        mem_hit;
  logic [1:0]        wb_hit;

  // ex_regwrite is not needed: a load always writes, so ex_memread alone identifies the hazard
  logic unused_ex_regwrite;
  assign unused_ex_regwrite = ex_regwrite;

  assign taken    = mem_branch & (mem_zr ^ mem_branchflip);
  assign redirect = taken | mem_jump;
  assign lh = ex_memread && (ex_wr_addr != '0) &&
              ((id_uses_rs && (id_rs == ex_wr_addr)) || (id_uses_rt && (id_rt == ex_wr_addr)));

  assign ex_src[0] = ex_rs;
  assign ex_src[1] = ex_rt;

  // Register 0 is hard-wired zero, so a write to it must never be forwarded
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign mem_hit[gi] = mem_regwrite && (mem_wr_addr != '0) && (mem_wr_addr == ex_src[gi]);
    assign wb_hit[gi]  = wb_regwrite  && (wb_wr_addr  != '0) && (wb_wr_addr  == ex_src[gi]);
  end

  assign fwd_a = reset ? 2'b00 : mem_hit[0] ? 2'b10 : wb_hit[0] ? 2'b01 : 2'b00;
  assign fwd_b = reset ? 2'b00 : mem_hit[1] ? 2'b10 : wb_hit[1] ? 2'b01 : 2'b00;

  assign stalled = !reset && (state_reg == STALL);

  always_comb begin
    pc_write    = 1'b0;
    pc_sel      = 2'b00;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (enable) begin
      if (redirect) begin
        // A redirect overrides both a fresh load-use hazard and an ongoing stall
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        pc_sel      = mem_jump ? 2'b10 : 2'b01;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if ((state_reg == STALL) || lh) begin
        idex_flush = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= 4'd0;
    end else if (enable) begin
      case (state_reg)
        RUN: begin
          if (!redirect && lh) begin
            cnt_reg <= STALL_INIT;
            if (MULTI_STALL) state_reg <= STALL;
          end
        end
        STALL: begin
          if (redirect) begin
            state_reg <= RUN;
            cnt_reg   <= 4'd0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) state_reg <= RUN;
          end
        end
        default: begin
          state_reg <= RUN;
          cnt_reg   <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_reg;
  logic [15:0] flush_cnt_reg;
  logic        bubble;

  assign bubble = !reset && enable && !redirect && ((state_reg == STALL) || lh);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= 16'd0;
      flush_cnt_reg <= 16'd0;
    end else begin
      if (bubble && (stall_cnt_reg != 16'hFFFF)) stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (enable && redirect && (flush_cnt_reg != 16'hFFFF)) flush_cnt_reg <= flush_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: three instances (STALL_CYCLES = 1, 3, 4) share one stimulus.
// Expected control vectors are queued as stimulus is applied and popped when the outputs settle.
module tb_pipeline_hazard_ctrl;
  localparam int AW = 5;

  // {pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b, stalled}
  localparam logic [11:0] E_RUN = 12'b1_00_1_000_00_00_0;
  localparam logic [11:0] E_BUB = 12'b0_00_0_010_00_00_0;
  localparam logic [11:0] E_STL = 12'b0_00_0_010_00_00_1;
  localparam logic [11:0] E_RST = 12'b0_00_0_111_00_00_0;
  localparam logic [11:0] E_BR  = 12'b1_01_1_111_00_00_0;
  localparam logic [11:0] E_JMP = 12'b1_10_1_111_00_00_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr_addr, mem_wr_addr, wb_wr_addr;
  logic id_uses_rs, id_uses_rt, ex_regwrite, ex_memread, mem_regwrite;
  logic mem_branch, mem_branchflip, mem_zr, mem_jump, wb_regwrite;

  logic        pc_write_o    [3];
  logic [1:0]  pc_sel_o      [3];
  logic        ifid_write_o  [3];
  logic        ifid_flush_o  [3];
  logic        idex_flush_o  [3];
  logic        exmem_flush_o [3];
  logic [1:0]  fwd_a_o       [3];
  logic [1:0]  fwd_b_o       [3];
  logic        stalled_o     [3];
  logic [11:0] obs           [3];
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_o [3];
  logic [15:0] flush_cnt_o [3];
`endif

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    pipeline_hazard_ctrl #(
      .STALL_CYCLES(gi == 0 ? 1 : (gi == 1 ? 3 : 4)),
      .REG_AW(AW)
    ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wr_addr(ex_wr_addr),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .mem_wr_addr(mem_wr_addr), .mem_regwrite(mem_regwrite),
      .mem_branch(mem_branch), .mem_branchflip(mem_branchflip), .mem_zr(mem_zr), .mem_jump(mem_jump),
      .wb_wr_addr(wb_wr_addr), .wb_regwrite(wb_regwrite),
      .pc_write(pc_write_o[gi]), .pc_sel(pc_sel_o[gi]), .ifid_write(ifid_write_o[gi]),
      .ifid_flush(ifid_flush_o[gi]), .idex_flush(idex_flush_o[gi]), .exmem_flush(exmem_flush_o[gi]),
      .fwd_a(fwd_a_o[gi]), .fwd_b(fwd_b_o[gi]),
`ifdef HAZARD_PERF_CNT_EN
      .stall_cnt(stall_cnt_o[gi]), .flush_cnt(flush_cnt_o[gi]),
`endif
      .stalled(stalled_o[gi])
    );
    assign obs[gi] = {pc_write_o[gi], pc_sel_o[gi], ifid_write_o[gi], ifid_flush_o[gi],
                      idex_flush_o[gi], exmem_flush_o[gi], fwd_a_o[gi], fwd_b_o[gi], stalled_o[gi]};
  end

  typedef struct {
    string       name;
    int          inst;
    logic [11:0] exp;
  } sb_t;
  sb_t sb_q[$];

  int checks = 0;
  int failures = 0;

  task automatic expect_ctl(input string n, input int i, input logic [11:0] e);
    sb_t t;
    t.name = n; t.inst = i; t.exp = e;
    sb_q.push_back(t);
  endtask

  task automatic clear_inputs();
    reset = 1'b0; enable = 1'b1;
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_wr_addr = '0; mem_wr_addr = '0; wb_wr_addr = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_regwrite = 1'b0; ex_memread = 1'b0; mem_regwrite = 1'b0;
    mem_branch = 1'b0; mem_branchflip = 1'b0; mem_zr = 1'b0; mem_jump = 1'b0; wb_regwrite = 1'b0;
  endtask

  task automatic set_lh();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wr_addr = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); clear_inputs(); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    sb_t it;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      clear_inputs();
      if (s == 0) begin
        reset = 1'b1; set_lh(); mem_jump = 1'b1;
        mem_regwrite = 1'b1; mem_wr_addr = 5'd3; ex_rs = 5'd3;
        for (int i = 0; i < 3; i++) expect_ctl("reset_outputs", i, E_RST);
      end else begin
        for (int i = 0; i < 3; i++) expect_ctl("after_reset", i, E_RUN);
      end
      #2;
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front(); checks++;
        if (obs[it.inst] !== it.exp) begin
          failures++;
          $display("FAIL %s step=%0d inst=%0d got=%b expected=%b", it.name, s, it.inst, obs[it.inst], it.exp);
        end else $display("ok %s step=%0d inst=%0d ctl=%b", it.name, s, it.inst, obs[it.inst]);
      end
    end
  endtask

  task automatic test_forwarding();
    sb_t it;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      clear_inputs();
      case (s)
        0: begin ex_rs = 5'd3; mem_regwrite = 1'b1; mem_wr_addr = 5'd3; wb_regwrite = 1'b1; wb_wr_addr = 5'd3;
                 expect_ctl("fwd_mem_prio", 0, 12'b1_00_1_000_10_00_0); end
        1: begin ex_rs = 5'd3; wb_regwrite = 1'b1; wb_wr_addr = 5'd3; mem_wr_addr = 5'd3;
                 expect_ctl("fwd_wb", 0, 12'b1_00_1_000_01_00_0); end
        2: begin ex_rs = 5'd0; wb_regwrite = 1'b1; wb_wr_addr = 5'd0;
                 expect_ctl("fwd_wb_r0", 0, E_RUN); end
        3: begin ex_rs = 5'd5; ex_rt = 5'd5; mem_regwrite = 1'b1; mem_wr_addr = 5'd5; wb_regwrite = 1'b1; wb_wr_addr = 5'd5;
                 expect_ctl("fwd_both_mem", 2, 12'b1_00_1_000_10_10_0); end
        4: begin mem_regwrite = 1'b1; wb_regwrite = 1'b1;
                 expect_ctl("fwd_mem_r0", 0, E_RUN); end
        default: begin ex_rs = 5'd7; ex_rt = 5'd6; mem_wr_addr = 5'd6; wb_regwrite = 1'b1; wb_wr_addr = 5'd6;
                 expect_ctl("fwd_b_wb", 1, 12'b1_00_1_000_00_01_0); end
      endcase
      #2;
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front(); checks++;
        if (obs[it.inst] !== it.exp) begin
          failures++;
          $display("FAIL %s step=%0d inst=%0d got=%b expected=%b", it.name, s, it.inst, obs[it.inst], it.exp);
        end else $display("ok %s step=%0d inst=%0d ctl=%b", it.name, s, it.inst, obs[it.inst]);
      end
    end
  endtask

  task automatic test_load_use_1();
    sb_t it;
    do_reset();
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      clear_inputs();
      case (s)
        0: begin set_lh(); expect_ctl("lu1_bubble", 0, E_BUB); end
        1: expect_ctl("lu1_resume", 0, E_RUN);
        2: begin ex_memread = 1'b1; ex_wr_addr = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
                 expect_ctl("lu1_rt_bubble", 0, E_BUB); end
        3: begin ex_memread = 1'b1; ex_wr_addr = 5'd9; id_rt = 5'd9;
                 expect_ctl("lu1_rt_unused", 0, E_RUN); end
        4: begin ex_memread = 1'b1; id_uses_rs = 1'b1;
                 expect_ctl("lu1_r0", 0, E_RUN); end
        default: begin ex_wr_addr = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b1;
                 expect_ctl("lu1_not_load", 0, E_RUN); end
      endcase
      #2;
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front(); checks++;
        if (obs[it.inst] !== it.exp) begin
          failures++;
          $display("FAIL %s step=%0d inst=%0d got=%b expected=%b", it.name, s, it.inst, obs[it.inst], it.exp);
        end else $display("ok %s step=%0d inst=%0d ctl=%b", it.name, s, it.inst, obs[it.inst]);
      end
    end
  endtask

  task automatic test_load_use_3();
    sb_t it;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      clear_inputs();
      case (s)
        0: begin set_lh(); expect_ctl("lu3_detect", 1, E_BUB); end
        1: begin expect_ctl("lu3_stall1", 1, E_STL); expect_ctl("lu3_sc1_run", 0, E_RUN); end
        2: expect_ctl("lu3_stall2", 1, E_STL);
        default: expect_ctl("lu3_run", 1, E_RUN);
      endcase
      #2;
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front(); checks++;
        if (obs[it.inst] !== it.exp) begin
          failures++;
          $display("FAIL %s step=%0d inst=%0d got=%b expected=%b", it.name, s, it.inst, obs[it.inst], it.exp);
        end else $display("ok %s step=%0d inst=%0d ctl=%b", it.name, s, it.inst, obs[it.inst]);
      end
    end
  endtask

  task automatic test_branch();
    sb_t it;
    do_reset();
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      clear_inputs();
      case (s)
        0: begin mem_branch = 1'b1; mem_zr = 1'b1; expect_ctl("br_taken", 0, E_BR); end
        1: begin mem_branch = 1'b1; mem_zr = 1'b1; mem_branchflip = 1'b1; expect_ctl("br_flip_not", 0, E_RUN); end
        2: begin mem_branch = 1'b1; mem_branchflip = 1'b1; expect_ctl("br_flip_taken", 0, E_BR); end
        3: begin mem_jump = 1'b1; expect_ctl("jump", 0, E_JMP); end
        4: begin mem_zr = 1'b1; expect_ctl("zr_no_branch", 0, E_RUN); end
        5: begin set_lh(); mem_branch = 1'b1; mem_zr = 1'b1; expect_ctl("br_over_lh", 1, E_BR); end
        default: expect_ctl("br_no_stall", 1, E_RUN);
      endcase
      #2;
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front(); checks++;
        if (obs[it.inst] !== it.exp) begin
          failures++;
          $display("FAIL %s step=%0d inst=%0d got=%b expected=%b", it.name, s, it.inst, obs[it.inst], it.exp);
        end else $display("ok %s step=%0d inst=%0d ctl=%b", it.name, s, it.inst, obs[it.inst]);
      end
    end
  endtask

  task automatic test_stall_redirect();
    sb_t it;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      clear_inputs();
      case (s)
        0: begin set_lh(); expect_ctl("sr_detect", 2, E_BUB); end
        1: expect_ctl("sr_stall", 2, E_STL);
        2: begin mem_jump = 1'b1; mem_branch = 1'b1; mem_zr = 1'b1;
                 expect_ctl("sr_abort_jump", 2, 12'b1_10_1_111_00_00_1); end
        default: expect_ctl("sr_run", 2, E_RUN);
      endcase
      #2;
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front(); checks++;
        if (obs[it.inst] !== it.exp) begin
          failures++;
          $display("FAIL %s step=%0d inst=%0d got=%b expected=%b", it.name, s, it.inst, obs[it.inst], it.exp);
        end else $display("ok %s step=%0d inst=%0d ctl=%b", it.name, s, it.inst, obs[it.inst]);
      end
    end
  endtask

  task automatic test_enable_freeze();
    sb_t it;
    do_reset();
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      clear_inputs();
      case (s)
        0: begin set_lh(); expect_ctl("en_detect", 1, E_BUB); end
        1: begin enable = 1'b0; expect_ctl("en_frozen", 1, 12'b0_00_0_000_00_00_1); end
        2: begin enable = 1'b0; mem_jump = 1'b1; mem_regwrite = 1'b1; mem_wr_addr = 5'd2; ex_rs = 5'd2;
                 expect_ctl("en_frozen_fwd", 1, 12'b0_00_0_000_10_00_1); end
        3: expect_ctl("en_stall1", 1, E_STL);
        4: expect_ctl("en_stall2", 1, E_STL);
        5: expect_ctl("en_run", 1, E_RUN);
        6: begin enable = 1'b0; set_lh(); expect_ctl("en_off_lh", 1, 12'b0_00_0_000_00_00_0); end
        default: expect_ctl("en_no_stall", 1, E_RUN);
      endcase
      #2;
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front(); checks++;
        if (obs[it.inst] !== it.exp) begin
          failures++;
          $display("FAIL %s step=%0d inst=%0d got=%b expected=%b", it.name, s, it.inst, obs[it.inst], it.exp);
        end else $display("ok %s step=%0d inst=%0d ctl=%b", it.name, s, it.inst, obs[it.inst]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    sb_t it;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      clear_inputs();
      case (s)
        0: begin set_lh(); expect_ctl("rm_detect", 2, E_BUB); end
        1: expect_ctl("rm_stall", 2, E_STL);
        2: begin reset = 1'b1; expect_ctl("rm_reset", 2, E_RST); end
        default: expect_ctl("rm_run", 2, E_RUN);
      endcase
      #2;
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front(); checks++;
        if (obs[it.inst] !== it.exp) begin
          failures++;
          $display("FAIL %s step=%0d inst=%0d got=%b expected=%b", it.name, s, it.inst, obs[it.inst], it.exp);
        end else $display("ok %s step=%0d inst=%0d ctl=%b", it.name, s, it.inst, obs[it.inst]);
      end
    end
  endtask

  task automatic test_back_to_back();
    sb_t it;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      clear_inputs();
      if (s < 4) set_lh();
      case (s)
        0: begin expect_ctl("b2b_sc1", 0, E_BUB); expect_ctl("b2b_sc3", 1, E_BUB); end
        1: begin expect_ctl("b2b_sc1", 0, E_BUB); expect_ctl("b2b_sc3", 1, E_STL); end
        2: begin expect_ctl("b2b_sc1", 0, E_BUB); expect_ctl("b2b_sc3", 1, E_STL); end
        3: begin expect_ctl("b2b_sc1", 0, E_BUB); expect_ctl("b2b_sc3", 1, E_BUB); end
        default: begin expect_ctl("b2b_sc1", 0, E_RUN); expect_ctl("b2b_sc3", 1, E_STL); end
      endcase
      #2;
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front(); checks++;
        if (obs[it.inst] !== it.exp) begin
          failures++;
          $display("FAIL %s step=%0d inst=%0d got=%b expected=%b", it.name, s, it.inst, obs[it.inst], it.exp);
        end else $display("ok %s step=%0d inst=%0d ctl=%b", it.name, s, it.inst, obs[it.inst]);
      end
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_counters();
    do_reset();
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      clear_inputs();
      if (s < 3) set_lh();
      else if (s < 5) mem_jump = 1'b1;
      else if (s == 5) begin enable = 1'b0; set_lh(); mem_jump = 1'b1; end
    end
    @(negedge clk); #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall_cnt_o[i] !== 16'd3) begin
        failures++; $display("FAIL perf_stall_cnt inst=%0d got=%0d expected=3", i, stall_cnt_o[i]);
      end else $display("ok perf_stall_cnt inst=%0d val=%0d", i, stall_cnt_o[i]);
      checks++;
      if (flush_cnt_o[i] !== 16'd2) begin
        failures++; $display("FAIL perf_flush_cnt inst=%0d got=%0d expected=2", i, flush_cnt_o[i]);
      end else $display("ok perf_flush_cnt inst=%0d val=%0d", i, flush_cnt_o[i]);
    end
    clear_inputs(); set_lh();
    repeat (65540) @(negedge clk);
    #2;
    checks++;
    if (stall_cnt_o[0] !== 16'hFFFF) begin
      failures++; $display("FAIL perf_stall_sat got=%h expected=ffff", stall_cnt_o[0]);
    end else $display("ok perf_stall_sat val=%h", stall_cnt_o[0]);
    do_reset();
    #2;
    checks++;
    if (stall_cnt_o[0] !== 16'd0) begin
      failures++; $display("FAIL perf_reset_clear got=%h expected=0000", stall_cnt_o[0]);
    end else $display("ok perf_reset_clear val=%h", stall_cnt_o[0]);
  endtask
`endif

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use_1();
    test_load_use_3();
    test_branch();
    test_stall_redirect();
    test_enable_freeze();
    test_reset_mid_stall();
    test_back_to_back();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and redirect controller for the 5-stage 8-bit pipeline (IF/ID/EX/MEM/WB).
- Generates operand-forwarding selects for the ALU inputs, load-use stalls (multi-cycle via an FSM with down-counter), and branch/jump redirect with pipeline flush.
- Branches and jumps resolve in MEM.
- Drives the PC write-enable, the IF/ID hold/flush, and ID/EX/EX/MEM bubble controls.

Parameters:
- STALL_CYCLES, 1, number of bubble cycles inserted per load-use hazard (1..15).
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- enable  in  1  global run enable; low freezes the pipeline
- id_rs / id_rt  in  REG_AW  source register addresses in ID
- id_uses_rs / id_uses_rt  in  1  ID instruction reads rs / rt
- ex_rs / ex_rt  in  REG_AW  source addresses of the instruction in EX
- ex_wr_addr  in  REG_AW  EX destination
- ex_regwrite / ex_memread  in  1  EX control bits
- mem_wr_addr  in  REG_AW  MEM destination
- mem_regwrite  in  1
- mem_branch / mem_branchflip / mem_zr / mem_jump  in  1  MEM branch info
- wb_wr_addr  in  REG_AW
- wb_regwrite  in  1
- pc_write  out  1  PC update enable
- pc_sel  out  2  00 pc+4, 01 MEM branch target, 10 MEM jump target
- ifid_write  out  1  IF/ID load enable
- ifid_flush / idex_flush / exmem_flush  out  1  zero the control bits of that register
- fwd_a / fwd_b  out  2  00 register file, 10 EX/MEM aluout, 01 MEM/WB write data
- stalled  out  1  FSM in STALL

Behaviour:
- Reset (synchronous, active-high) puts the FSM in RUN with stall counter 0. Outputs in the reset cycle:
  - pc_write=0, ifid_write=0, all flushes=1, pc_sel=00, fwd_a=fwd_b=00, stalled=0.
- Forwarding (combinational):
  - fwd_a=10 if mem_regwrite, mem_wr_addr!=0 and mem_wr_addr==ex_rs.
  - Else fwd_a=01 if wb_regwrite, wb_wr_addr!=0 and wb_wr_addr==ex_rs.
  - Else fwd_a=00. fwd_b is identical using ex_rt.
  - MEM has priority over WB. Address 0 is never forwarded.
- taken = mem_branch & (mem_zr ^ mem_branchflip); redirect = taken | mem_jump.
- Load hazard: lh = ex_memread & ex_wr_addr!=0 & ((id_uses_rs & id_rs==ex_wr_addr) | (id_uses_rt & id_rt==ex_wr_addr)).
- FSM states: RUN, STALL.
  - RUN, outputs: pc_write=1, ifid_write=1, no flush, pc_sel=00.
  - RUN, redirect: pc_sel = 10 if mem_jump, else 01 (jump wins over a simultaneous branch). Assert ifid_flush, idex_flush and exmem_flush the same cycle. Stay in RUN. Redirect has priority over lh; no stall is entered.
  - RUN, lh and no redirect: pc_write=0, ifid_write=0, idex_flush=1. Load counter with STALL_CYCLES-1. Go to STALL if STALL_CYCLES>1, else remain in RUN.
  - STALL: pc_write=0, ifid_write=0, idex_flush=1, stalled=1. Decrement the counter each enabled cycle. At counter==1, next state is RUN.
  - STALL with redirect: abort the stall, perform the redirect as in RUN, clear the counter, go to RUN.
- enable=0: pc_write=0, ifid_write=0, flushes=0. FSM and counter hold. Forwarding outputs stay live.
- Reset mid-stall returns to RUN next cycle with the counter cleared.
- Latency: all controls except FSM/counter are combinational from current-cycle inputs. The FSM updates on the rising clk edge.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments on each enabled cycle with idex_flush due to a stall.
  - flush_cnt increments on each redirect.
  - Both saturate at 16'hFFFF and are cleared by reset.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- RAW forwarding: ex_rs=3; mem_regwrite=1, mem_wr_addr=3; wb_regwrite=1, wb_wr_addr=3 -> fwd_a=10. Drop mem_regwrite -> fwd_a=01. Set ex_rs=0 -> fwd_a=00.
- Load-use, STALL_CYCLES=1: ex_memread=1, ex_wr_addr=4, id_rs=4, id_uses_rs=1 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1. Next cycle pc_write=1.
- Load-use, STALL_CYCLES=3 -> stalled=1 for 2 cycles after detection, 3 bubble cycles total, then RUN.
- Branch: mem_branch=1, mem_zr=1, mem_branchflip=0 -> pc_sel=01 plus all three flushes for 1 cycle. With mem_branchflip=1 -> pc_sel=00, no flush.
- Redirect during STALL (STALL_CYCLES=4) and simultaneous jump+branch -> stall aborts, pc_sel=10, FSM to RUN.
- enable=0 during STALL freezes the counter. reset=1 mid-stall -> RUN, stalled=0 next cycle. With HAZARD_PERF_CNT_EN, stall_cnt/flush_cnt match the bubble/redirect counts and saturate at FFFF.
